intersection_ctrl: RTL and testbench
====================================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 The block SHALL provide the ports below (name, direction, width, meaning), with clock and reset first.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  timing strobe, one clk wide; all phase timers advance only on cycles where tick=1.
REQ-005 cfg_we  input  1  duration-register write enable.
REQ-006 cfg_addr  input  2  register select: 0=GREEN, 1=YELLOW, 2=ALLRED, 3=WALK.
REQ-007 cfg_data  input  6  duration in ticks.
REQ-008 ped_req  input  1  pedestrian request; any cycle high sets the pending flag.
REQ-009 ns_r, ns_y, ns_g  output  1 each  north-south lamps.
REQ-010 ew_r, ew_y, ew_g  output  1 each  east-west lamps.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 ped_ack  output  1  one-cycle pulse on entry to WALK.
REQ-013 The block SHALL have the following duration-register reset defaults (name, default, meaning): GREEN 15, green-phase ticks; YELLOW 2, yellow-phase ticks; ALLRED 1, clearance ticks; WALK 8, walk ticks.

Function
REQ-014 The block SHALL implement the states IDLE, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2 and WALK.
REQ-015 The block SHALL leave IDLE for NS_G after exactly one clk cycle.
REQ-016 The state sequence SHALL be NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-017 At the end of AR1 or AR2 with pending=1, the block SHALL enter WALK, then go to the green that would otherwise have followed (after AR1: EW_G; after AR2: NS_G).
REQ-018 Each timed state SHALL last exactly D ticks, where D is its duration register; D=0 SHALL be treated as 1.
REQ-019 A 6-bit down-counter SHALL be loaded on state entry and decremented on tick; the transition SHALL occur at the clk edge following the cycle in which the D-th tick arrives.
REQ-020 The duration SHALL be sampled at the state-entry edge; a write on that same edge SHALL take effect from the next entry, and writes mid-phase SHALL NOT alter the current phase.
REQ-021 The lamp outputs SHALL be registered and decoded from the state, with exactly one of r/y/g high per road at all times.
REQ-022 In NS_G and NS_Y, the block SHALL drive ns_g or ns_y respectively, and ew_r=1.
REQ-023 In EW_G and EW_Y, the block SHALL drive ew_g or ew_y respectively, and ns_r=1.
REQ-024 In IDLE, AR1, AR2 and WALK, the block SHALL drive both reds high.
REQ-025 The block SHALL drive walk=1 only in WALK.
REQ-026 The pending flag SHALL be set by ped_req in any state and cleared on WALK entry.
REQ-027 If ped_req and WALK entry coincide, pending SHALL remain set, so one further WALK is served later.
REQ-028 The block SHALL raise ped_ack for exactly one clk cycle, on the cycle after the WALK-entry edge.
REQ-029 No green SHALL ever be asserted on both roads simultaneously, and green SHALL never follow yellow without an intervening AR state.

Reset
REQ-030 While rst=1 the block SHALL hold: state=IDLE, ns_r=ew_r=1, all yellow/green=0, walk=0, ped_ack=0, pending=0, counter=0, duration registers at defaults.
REQ-031 Assertion of rst mid-phase SHALL force the REQ-030 values immediately, without waiting for clk.
REQ-032 After rst deasserts, the block SHALL enter NS_G on the second rising clk edge.

Verification
REQ-033 The bench SHALL cover: defaults with tick every cycle -> NS_G 15 cycles, NS_Y 2, AR1 1, EW_G 15, EW_Y 2, AR2 1; full period 36 cycles.
REQ-034 The bench SHALL cover: ped_req pulse during NS_G -> after AR1, WALK for 8 ticks, walk=1, one ped_ack pulse, then EW_G; no second WALK.
REQ-035 The bench SHALL cover: write GREEN=3 mid-NS_G -> current NS_G still 15 ticks, next EW_G 3 ticks; write YELLOW=0 -> yellow lasts 1 tick.
REQ-036 The bench SHALL cover: tick every 4th cycle -> all phase lengths scale by 4, with lamps stable between ticks.
REQ-037 The bench SHALL cover: rst asserted during EW_Y, between edges -> reds high and ew_y=0 immediately; restart at NS_G.
REQ-038 The bench SHALL check continuously: never ns_g&ew_g, never walk with any green or yellow, and one-hot r/y/g per road.

Source files
------------

// File: rtl/intersection_ctrl_if.sv
// Signal bundle between an intersection controller and whatever drives it.
//   tick      timing strobe, one clk wide; phase timers only advance on it
//   cfg_we    duration-register write enable
//   cfg_addr  register select: 0=GREEN, 1=YELLOW, 2=ALLRED, 3=WALK
//   cfg_data  duration in ticks
//   ped_req   pedestrian request (level sampled every cycle)
//   ns_r/y/g  north-south lamps
//   ew_r/y/g  east-west lamps
//   walk      pedestrian walk lamp
//   ped_ack   one-cycle pulse when a walk phase is entered
// master: the side that issues tick/config/requests and watches the lamps.
// slave:  the controller itself.
interface intersection_ctrl_if;
  logic       tick;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [5:0] cfg_data;
  logic       ped_req;
  logic       ns_r;
  logic       ns_y;
  logic       ns_g;
  logic       ew_r;
  logic       ew_y;
  logic       ew_g;
  logic       walk;
  logic       ped_ack;

  modport master (
    output tick, cfg_we, cfg_addr, cfg_data, ped_req,
    input  ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack
  );

  modport slave (
    input  tick, cfg_we, cfg_addr, cfg_data, ped_req,
    output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack
  );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-road traffic-light controller with a pedestrian walk phase.
// Cycle: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G. A pending
// pedestrian request inserts WALK after an all-red phase, after which the
// green that would have followed is served.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  intersection_ctrl_if.slave (tick, config writes, ped_req in;
//        registered lamps, walk and ped_ack out)
module intersection_ctrl (
  input  logic                clk,
  input  logic                rst,
  intersection_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, WALK
  } state_t;

  localparam logic [1:0] SEL_GREEN  = 2'd0;
  localparam logic [1:0] SEL_YELLOW = 2'd1;
  localparam logic [1:0] SEL_ALLRED = 2'd2;
  localparam logic [1:0] SEL_WALK   = 2'd3;

  localparam logic [5:0] DUR_DEFAULT [4] = '{6'd15, 6'd2, 6'd1, 6'd8};

  // Lamp vector layout: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  localparam logic [6:0] LAMP_ALLRED = 7'b1001000;

  state_t     state_reg, state_next;
  state_t     succ;
  logic [5:0] cnt_reg, cnt_next;
  logic       pending_reg, pending_next;
  logic       ret_ns_reg, ret_ns_next;   // WALK returns to NS_G when set, else EW_G
  logic       ped_ack_reg, ped_ack_next;
  logic [6:0] lamp_reg, lamp_next;
  logic       go;
  logic       walk_entry;
  logic [5:0] dur_raw;
  logic [5:0] dur_val [4];

  // Duration registers. A write lands on the clock edge, so a state entered
  // on that same edge still loads the old value.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dur
      logic [5:0] dur_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dur_q <= DUR_DEFAULT[gi];
        end else if (bus.cfg_we && bus.cfg_addr == 2'(gi)) begin
          dur_q <= bus.cfg_data;
        end
      end
      assign dur_val[gi] = dur_q;
    end
  endgenerate

  function automatic logic [1:0] dur_sel(input state_t s);
    case (s)
      NS_G, EW_G: dur_sel = SEL_GREEN;
      NS_Y, EW_Y: dur_sel = SEL_YELLOW;
      WALK:       dur_sel = SEL_WALK;
      default:    dur_sel = SEL_ALLRED;
    endcase
  endfunction

  function automatic logic [6:0] lamps_of(input state_t s);
    case (s)
      NS_G:    lamps_of = 7'b0011000;
      NS_Y:    lamps_of = 7'b0101000;
      EW_G:    lamps_of = 7'b1000010;
      EW_Y:    lamps_of = 7'b1000100;
      WALK:    lamps_of = 7'b1001001;
      default: lamps_of = LAMP_ALLRED;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 6'd0;
      pending_reg <= 1'b0;
      ret_ns_reg  <= 1'b0;
      ped_ack_reg <= 1'b0;
      lamp_reg    <= LAMP_ALLRED;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      ret_ns_reg  <= ret_ns_next;
      ped_ack_reg <= ped_ack_next;
      lamp_reg    <= lamp_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ret_ns_next = ret_ns_reg;
    go          = 1'b0;
    dur_raw     = 6'd0;

    // Successor if the current phase ends this cycle.
    case (state_reg)
      NS_G:    succ = NS_Y;
      NS_Y:    succ = AR1;
      AR1:     succ = pending_reg ? WALK : EW_G;
      EW_G:    succ = EW_Y;
      EW_Y:    succ = AR2;
      AR2:     succ = pending_reg ? WALK : NS_G;
      WALK:    succ = ret_ns_reg ? NS_G : EW_G;
      default: succ = NS_G;
    endcase

    if (state_reg == IDLE) begin
      // The counter is 0 straight out of reset; the first edge marks it so
      // that the second edge moves on to NS_G.
      if (cnt_reg == 6'd0) begin
        cnt_next = 6'd1;
      end else begin
        go = 1'b1;
      end
    end else if (bus.tick) begin
      if (cnt_reg <= 6'd1) begin
        go = 1'b1;
      end else begin
        cnt_next = cnt_reg - 6'd1;
      end
    end

    if (go) begin
      state_next = succ;
      dur_raw    = dur_val[dur_sel(succ)];
      cnt_next   = (dur_raw == 6'd0) ? 6'd1 : dur_raw;
      if (succ == WALK) begin
        ret_ns_next = (state_reg == AR2);
      end
    end

    walk_entry = go && (succ == WALK);
    // A request arriving on the entry edge itself survives, so it earns
    // another walk later.
    pending_next = bus.ped_req | (pending_reg & ~walk_entry);
    ped_ack_next = walk_entry;
    lamp_next    = lamps_of(state_next);
  end

  assign bus.ns_r    = lamp_reg[6];
  assign bus.ns_y    = lamp_reg[5];
  assign bus.ns_g    = lamp_reg[4];
  assign bus.ew_r    = lamp_reg[3];
  assign bus.ew_y    = lamp_reg[2];
  assign bus.ew_g    = lamp_reg[1];
  assign bus.walk    = lamp_reg[0];
  assign bus.ped_ack = ped_ack_reg;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: a phase-level reference model predicts the
// lamp vector after every clock edge into a queue; an independent monitor
// pops and compares. Directed scenarios also check phase run lengths.
module tb_intersection_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  intersection_ctrl_if bus();

  intersection_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int fail_lines = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (fail_lines < 50) $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      fail_lines++;
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_NSG, M_NSY, M_AR1, M_EWG, M_EWY, M_AR2, M_WALK} mph_t;
  mph_t m_ph    = M_IDLE;
  mph_t m_ret   = M_NSG;
  int   m_ticks = 0;
  int   m_len   = 0;
  int   m_idle  = 0;
  bit   m_pend  = 0;
  bit   m_ack   = 0;
  int   m_dur[4] = '{15, 2, 1, 8};
  logic [7:0] exp_q[$];
  bit started = 0;

  function automatic int phase_len(input mph_t p);
    int d;
    case (p)
      M_NSG, M_EWG: d = m_dur[0];
      M_NSY, M_EWY: d = m_dur[1];
      M_WALK:       d = m_dur[3];
      default:      d = m_dur[2];
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack}
  function automatic logic [7:0] lamps(input mph_t p, input bit ack);
    logic [6:0] l;
    case (p)
      M_NSG:   l = 7'b0011000;
      M_NSY:   l = 7'b0101000;
      M_EWG:   l = 7'b1000010;
      M_EWY:   l = 7'b1000100;
      M_WALK:  l = 7'b1001001;
      default: l = 7'b1001000;
    endcase
    return {l, ack};
  endfunction

  task automatic model_step();
    bit   go;
    mph_t nxt;
    go  = 0;
    nxt = m_ph;
    if (m_ph == M_IDLE) begin
      m_idle++;
      if (m_idle >= 2) begin go = 1; nxt = M_NSG; end
    end else if (bus.tick) begin
      m_ticks++;
      if (m_ticks >= m_len) begin
        go = 1;
        case (m_ph)
          M_NSG: nxt = M_NSY;
          M_NSY: nxt = M_AR1;
          M_AR1: if (m_pend) begin nxt = M_WALK; m_ret = M_EWG; end else nxt = M_EWG;
          M_EWG: nxt = M_EWY;
          M_EWY: nxt = M_AR2;
          M_AR2: if (m_pend) begin nxt = M_WALK; m_ret = M_NSG; end else nxt = M_NSG;
          M_WALK: nxt = m_ret;
          default: nxt = M_NSG;
        endcase
      end
    end
    m_ack = go && (nxt == M_WALK);
    if (go) begin
      m_ph    = nxt;
      m_ticks = 0;
      m_len   = phase_len(nxt);
    end
    m_pend = m_ack ? bus.ped_req : (m_pend | bus.ped_req);
    if (bus.cfg_we) m_dur[bus.cfg_addr] = int'(bus.cfg_data);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = M_IDLE; m_ticks = 0; m_len = 0; m_idle = 0;
      m_pend = 0; m_ack = 0; m_dur = '{15, 2, 1, 8};
      exp_q.delete();
      exp_q.push_back(lamps(M_IDLE, 1'b0));
    end else begin
      model_step();
      exp_q.push_back(lamps(m_ph, m_ack));
    end
    started = 1;
  end

  // ---------------- monitors ----------------
  function automatic logic [7:0] dut_vec();
    return {bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g, bus.walk, bus.ped_ack};
  endfunction

  int sb_cyc = 0;
  always @(negedge clk) begin
    logic [7:0] want;
    sb_cyc++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check($sformatf("scoreboard cyc=%0d", sb_cyc), 32'(dut_vec()), 32'(want));
    end
  end

  always @(negedge clk) begin
    logic ok;
    if (started) begin
      ok = !(bus.ns_g && bus.ew_g)
        && !(bus.walk && (bus.ns_g || bus.ns_y || bus.ew_g || bus.ew_y))
        && ((32'(bus.ns_r) + 32'(bus.ns_y) + 32'(bus.ns_g)) == 1)
        && ((32'(bus.ew_r) + 32'(bus.ew_y) + 32'(bus.ew_g)) == 1);
      check("invariants", 32'(ok), 32'd1);
    end
  end

  // Phase-run tracker: one line per completed phase.
  typedef struct { int code; int len; int start; } run_t;
  run_t run_q[$];
  int cur_code = -1;
  int cur_len  = 0;
  int cur_start = 0;
  int mcyc = 0;
  int ack_cnt = 0;

  function automatic int lamp_code();
    if (bus.walk && bus.ns_r && bus.ew_r) return 5;
    if (bus.ns_g) return 1;
    if (bus.ns_y) return 2;
    if (bus.ew_g) return 3;
    if (bus.ew_y) return 4;
    if (bus.ns_r && bus.ew_r) return 0;
    return 6;
  endfunction

  function automatic string code_name(input int c);
    case (c)
      0: return "ALLRED";
      1: return "NS_G";
      2: return "NS_Y";
      3: return "EW_G";
      4: return "EW_Y";
      5: return "WALK";
      default: return "BAD";
    endcase
  endfunction

  always @(negedge clk) begin
    int code;
    run_t r;
    mcyc++;
    if (rst) begin
      cur_code = -1;
    end else begin
      code = lamp_code();
      if (bus.ped_ack) ack_cnt++;
      if (code != cur_code) begin
        if (cur_code >= 0) begin
          r.code = cur_code; r.len = cur_len; r.start = cur_start;
          run_q.push_back(r);
          $display("phase %s start=%0d len=%0d", code_name(cur_code), cur_start, cur_len);
          check("yellow_then_green", 32'((cur_code == 2 || cur_code == 4) && (code == 1 || code == 3)), 32'd0);
        end
        cur_code = code; cur_len = 1; cur_start = mcyc;
      end else begin
        cur_len++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int tick_div = 1;
  bit rand_mode = 0;
  int scyc = 0;
  int ec[8];
  int el[8];

  task automatic step(input bit ped, input bit we, input logic [1:0] a, input logic [5:0] d);
    @(negedge clk);
    scyc++;
    if (rand_mode) bus.tick = ($urandom_range(1, 0) == 1);
    else           bus.tick = ((scyc % tick_div) == 0);
    bus.ped_req  = ped;
    bus.cfg_we   = we;
    bus.cfg_addr = a;
    bus.cfg_data = d;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 6'd0);
  endtask

  task automatic release_reset();
    bus.ped_req = 0; bus.cfg_we = 0; bus.tick = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_q.delete();
    ack_cnt = 0;
    scyc = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    release_reset();
  endtask

  // which: 0 = ns_g, 1 = ew_y
  task automatic wait_lamp(input string tag, input int which);
    bit found;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      if ((which == 0 && bus.ns_g) || (which == 1 && bus.ew_y)) begin
        found = 1;
        break;
      end
      idle_n(1);
    end
    check({tag, " wait"}, 32'(found), 32'd1);
  endtask

  task automatic expect_seq(input string tag, input int n);
    int  i0;
    bit  present;
    i0 = -1;
    for (int j = 0; j < run_q.size(); j++) begin
      if (run_q[j].code == ec[0]) begin i0 = j; break; end
    end
    for (int k = 0; k < n; k++) begin
      present = (i0 >= 0) && (i0 + k < run_q.size());
      check($sformatf("%s run%0d present", tag, k), 32'(present), 32'd1);
      if (present) begin
        check($sformatf("%s run%0d code", tag, k), 32'(run_q[i0 + k].code), 32'(ec[k]));
        check($sformatf("%s run%0d len", tag, k), 32'(run_q[i0 + k].len), 32'(el[k]));
      end
    end
  endtask

  initial begin
    int s_a;
    int s_b;
    int walks;
    bus.tick = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.ped_req = 0;

    // Defaults, tick every cycle.
    release_reset();
    idle_n(100);
    ec = '{1, 2, 0, 3, 4, 0, 1, 0};
    el = '{15, 2, 1, 15, 2, 1, 15, 0};
    expect_seq("s1", 7);
    s_a = -1; s_b = -1;
    foreach (run_q[j]) begin
      if (run_q[j].code == 1) begin
        if (s_a < 0) s_a = run_q[j].start;
        else if (s_b < 0) s_b = run_q[j].start;
      end
    end
    check("s1 period", 32'(s_b - s_a), 32'd36);

    // Pedestrian request during NS_G.
    do_reset();
    wait_lamp("s2", 0);
    idle_n(4);
    step(1'b1, 1'b0, 2'd0, 6'd0);
    idle_n(100);
    ec = '{1, 2, 0, 5, 3, 4, 0, 1};
    el = '{15, 2, 1, 8, 15, 2, 1, 15};
    expect_seq("s2", 8);
    walks = 0;
    foreach (run_q[j]) if (run_q[j].code == 5) walks++;
    check("s2 walk count", 32'(walks), 32'd1);
    check("s2 ped_ack pulses", 32'(ack_cnt), 32'd1);

    // Mid-phase writes: GREEN=3, YELLOW=0.
    do_reset();
    wait_lamp("s3", 0);
    idle_n(4);
    step(1'b0, 1'b1, 2'd0, 6'd3);
    step(1'b0, 1'b1, 2'd1, 6'd0);
    idle_n(60);
    ec = '{1, 2, 0, 3, 4, 0, 1, 2};
    el = '{15, 1, 1, 3, 1, 1, 3, 1};
    expect_seq("s3", 8);

    // Tick every 4th cycle.
    tick_div = 4;
    do_reset();
    idle_n(300);
    ec = '{2, 0, 3, 4, 0, 1, 2, 0};
    el = '{8, 4, 60, 8, 4, 60, 8, 0};
    expect_seq("s4", 7);
    tick_div = 1;

    // Asynchronous reset during EW_Y.
    do_reset();
    wait_lamp("s6", 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("s6 async reset lamps", 32'(dut_vec()), 32'h90);
    release_reset();
    idle_n(1);
    check("s6 idle after first edge", 32'(bus.ns_g), 32'd0);
    idle_n(1);
    check("s6 ns_g on second edge", 32'(bus.ns_g), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      step($urandom_range(19, 0) == 0, $urandom_range(29, 0) == 0,
           2'($urandom_range(3, 0)), 6'($urandom_range(6, 0)));
    end
    rand_mode = 0;
    idle_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
